// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with a bounded hold time.
// Each grant is followed by a single idle bubble. A timeout pulse flags a grant that was cut off by the hold limit.
//   state   | meaning
//   S_IDLE  | no owner; arbitrate among pending requests
//   S_GRANT | one requester owns the resource; count hold cycles
module arb4_rr #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [0:0] state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] gnt_q, gnt_d;
    logic       timeout_q, timeout_d;

    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    logic       owner_req;
    logic       at_limit;
    logic       grant_end;

    // Search starts just after the last owner and wraps; k=4 lands back on the last owner.
    always_comb begin
        winner = last_q;
        cand   = last_q;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign owner_req = req[last_q];
    assign at_limit  = (hold_q == HOLD_LAST);
    assign grant_end = rel | ~owner_req | at_limit;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANT;
                    last_d  = winner;
                    hold_d  = 4'd0;
                    gnt_d   = 4'b0001 << winner;
                end
            end
            S_GRANT: begin
                if (grant_end) begin
                    state_d   = S_IDLE;
                    gnt_d     = 4'b0000;
                    // A release or a dropped request wins over a coincident hold limit.
                    timeout_d = at_limit & ~rel & owner_req;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            last_q    <= 2'd3;
            hold_q    <= 4'd0;
            gnt_q     <= 4'b0000;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = last_q;
    assign gnt_valid = (state_q == S_GRANT);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_arb4_rr.sv
// Bench for arb4_rr: two instances (hold limits 8 and 4) against a behavioural model.
// Directed scenarios with literal expectations run first, followed by randomized traffic.
module tb_arb4_rr;

    typedef struct {
        int owner;
        int last;
        int len;
        bit to;
    } mstate_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rel;

    logic [3:0] gnt8, gnt4;
    logic [1:0] idx8, idx4;
    logic       val8, val4;
    logic       to8, to4;

    int checks = 0;
    int errors = 0;

    mstate_t m[2];
    int      maxh[2] = '{8, 4};

    arb4_rr #(.MAX_HOLD(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
        .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(val8), .timeout(to8)
    );

    arb4_rr #(.MAX_HOLD(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
        .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4), .timeout(to4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic mstate_t model_reset();
        mstate_t s;
        s.owner = -1;
        s.last  = 3;
        s.len   = 0;
        s.to    = 1'b0;
        return s;
    endfunction

    // One cycle of arbiter behaviour: a grant lasts len = 1..mh cycles, then one free cycle.
    function automatic mstate_t model_step(mstate_t s, logic [3:0] r, logic rl, int mh);
        mstate_t n;
        int c;
        n = s;
        n.to = 1'b0;
        if (s.owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                c = (s.last + k) % 4;
                if (n.owner < 0 && r[c]) begin
                    n.owner = c;
                    n.last  = c;
                    n.len   = 1;
                end
            end
        end else if (rl || !r[s.owner] || s.len == mh) begin
            n.to    = !rl && r[s.owner];
            n.owner = -1;
        end else begin
            n.len = s.len + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) m[d] <= model_reset();
            else        m[d] <= model_step(m[d], req, rel, maxh[d]);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_gnt(mstate_t s);
        return (s.owner >= 0) ? (4'b0001 << s.owner) : 4'b0000;
    endfunction

    always @(negedge clk) begin
        chk("m8_gnt",     {4'b0, gnt8},  {4'b0, exp_gnt(m[0])});
        chk("m8_idx",     {6'b0, idx8},  8'(m[0].last));
        chk("m8_valid",   {7'b0, val8},  {7'b0, m[0].owner >= 0});
        chk("m8_timeout", {7'b0, to8},   {7'b0, m[0].to});
        chk("m4_gnt",     {4'b0, gnt4},  {4'b0, exp_gnt(m[1])});
        chk("m4_idx",     {6'b0, idx4},  8'(m[1].last));
        chk("m4_valid",   {7'b0, val4},  {7'b0, m[1].owner >= 0});
        chk("m4_timeout", {7'b0, to4},   {7'b0, m[1].to});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 4'b0000;
        rel = 1'b0;
        repeat (n) tick();
    endtask

    logic [3:0] rr_seq[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        req   = 4'b0000;
        rel   = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",     {4'b0, gnt8}, 8'h00);
        chk("rst_idx",     {6'b0, idx8}, 8'h03);
        chk("rst_valid",   {7'b0, val8}, 8'h00);
        chk("rst_timeout", {7'b0, to8},  8'h00);

        // Full request set with release on the third grant cycle rotates 0,1,2,3,0.
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("rr_order8", {4'b0, gnt8}, {4'b0, rr_seq[i]});
            chk("rr_order4", {4'b0, gnt4}, {4'b0, rr_seq[i]});
            tick();
            tick();
            rel = 1'b1;
            tick();
            rel = 1'b0;
            @(negedge clk);
            chk("rr_bubble", {4'b0, gnt8}, 8'h00);
        end
        idle(3);

        // Single requester held: hold limit of 8 cycles, timeout pulse, regrant.
        req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            chk("hold_gnt", {4'b0, gnt8}, 8'h04);
            chk("hold_to",  {7'b0, to8},  8'h00);
        end
        tick();
        @(negedge clk);
        chk("limit_gnt", {4'b0, gnt8}, 8'h00);
        chk("limit_to",  {7'b0, to8},  8'h01);
        chk("limit_idx", {6'b0, idx8}, 8'h02);
        tick();
        @(negedge clk);
        chk("regrant_gnt", {4'b0, gnt8}, 8'h04);
        chk("regrant_to",  {7'b0, to8},  8'h00);
        idle(3);

        // Owner 1 drops its request in grant cycle 2; requester 3 is next.
        req = 4'b0010;
        tick();
        @(negedge clk);
        chk("drop_own", {4'b0, gnt8}, 8'h02);
        req = 4'b1011;
        tick();
        req = 4'b1001;
        @(negedge clk);
        chk("drop_c2", {4'b0, gnt8}, 8'h02);
        tick();
        @(negedge clk);
        chk("drop_bub", {4'b0, gnt8}, 8'h00);
        chk("drop_to",  {7'b0, to8},  8'h00);
        tick();
        @(negedge clk);
        chk("drop_next", {4'b0, gnt8}, 8'h08);
        idle(3);

        // Release coinciding with the 4-cycle hold limit is not a timeout.
        req = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        rel = 1'b1;
        @(negedge clk);
        chk("rel4_c4", {4'b0, gnt4}, 8'h01);
        tick();
        rel = 1'b0;
        @(negedge clk);
        chk("rel4_gnt", {4'b0, gnt4}, 8'h00);
        chk("rel4_to",  {7'b0, to4},  8'h00);
        idle(3);

        // Asynchronous reset mid-grant, then requester 0 has top priority again.
        req = 4'b0010;
        tick();
        @(negedge clk);
        chk("ar_pre", {4'b0, gnt8}, 8'h02);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_gnt",   {4'b0, gnt8}, 8'h00);
        chk("ar_idx",   {6'b0, idx8}, 8'h03);
        chk("ar_valid", {7'b0, val8}, 8'h00);
        req = 4'b0110;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("ar_first", {4'b0, gnt8}, 8'h02);
        idle(3);

        // No requests with rel toggling: nothing is ever granted.
        for (int i = 0; i < 20; i++) begin
            rel = 1'($urandom_range(0, 1));
            tick();
            @(negedge clk);
            chk("quiet_gnt",   {4'b0, gnt8}, 8'h00);
            chk("quiet_valid", {7'b0, val8}, 8'h00);
            chk("quiet_to",    {7'b0, to8},  8'h00);
        end
        rel = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rel = ($urandom_range(0, 7) == 0);
            if (i % 700 == 350) begin
                #2 rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb4_rr.md
ARB4_RR -- requirements
Module: arb4_rr

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8: the maximum number of consecutive cycles one grant is held; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester request level; req[i] belongs to requester i.
REQ-005 The block SHALL have port rel, input, 1 bit: the current owner releases the resource.
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-007 The block SHALL have port gnt_idx, output, 2 bits: binary index of the current or last owner.
REQ-008 The block SHALL have port gnt_valid, output, 1 bit: high while a grant is active.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 The block SHALL be a two-state FSM with states IDLE and GRANT.
REQ-011 In IDLE with req != 0, the block SHALL choose the winner round-robin, searching from (last_idx+1) mod 4 upward with wrap; it SHALL enter GRANT at the next edge.
REQ-012 The grant latency SHALL be 1 cycle: req sampled high in IDLE gives gnt asserted from the following cycle.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE; gnt SHALL be 4'b0000 and gnt_valid 0.
REQ-014 In GRANT, gnt SHALL equal the 2-to-4 one-hot decode of gnt_idx (00->0001, 01->0010, 10->0100, 11->1000) and gnt_valid SHALL be 1.
REQ-015 gnt and gnt_idx SHALL be stable for the whole of GRANT.
REQ-016 hold_cnt SHALL clear on entry to GRANT and increment each GRANT cycle; width 4 bits; no wrap is possible within the legal range.
REQ-017 The grant SHALL end after the current cycle when rel=1, when req[gnt_idx]=0, or when hold_cnt == MAX_HOLD-1; a grant therefore lasts 1..MAX_HOLD cycles.
REQ-018 On grant end the FSM SHALL return to IDLE for exactly one bubble cycle; there is no back-to-back grant.
REQ-019 last_idx SHALL update to the winner on entry to GRANT; gnt_idx SHALL hold last_idx in IDLE.
REQ-020 timeout SHALL pulse for 1 cycle, the first IDLE cycle, only when the end was caused solely by the hold limit, with rel=0 and req[gnt_idx]=1.
REQ-021 When rel or request drop coincides with the hold limit, the end SHALL be treated as a release and timeout SHALL stay 0.
REQ-022 rel asserted in IDLE SHALL be ignored.
REQ-023 A requester whose request is revoked SHALL get no special priority; round-robin SHALL continue from its index.

Reset
REQ-024 On rst_n=0 the block SHALL take, immediately and regardless of clk: state=IDLE, gnt=4'b0000, gnt_valid=0, gnt_idx=2'b11, last_idx=3, hold_cnt=0, timeout=0.
REQ-025 Reset mid-grant SHALL drop the grant immediately; after release of reset, requester 0 SHALL have top priority.
REQ-026 Reset release SHALL be synchronous to clk; the first arbitration SHALL occur on the first edge with rst_n=1.

Verification
REQ-027 After reset, req=4'b1111 held, rel pulsed on the 3rd grant cycle of each owner -> gnt sequence 0001, 0010, 0100, 1000, 0001, each separated by one gnt=0000 cycle.
REQ-028 MAX_HOLD=8, req=4'b0100 held, rel=0 -> gnt=0100 for exactly 8 cycles, then gnt=0000 with timeout=1 for 1 cycle, then gnt=0100 again.
REQ-029 Owner 1 granted, req[1] drops in grant cycle 2 with req=4'b1001 pending -> gnt=0000 for 1 cycle, then gnt=1000, timeout=0.
REQ-030 MAX_HOLD=4, rel=1 exactly in grant cycle 4 -> grant ends after 4 cycles, timeout stays 0.
REQ-031 rst_n dropped asynchronously mid-grant with gnt=0010 -> gnt=0000 and gnt_idx=11 before the next clk edge; after release, req=4'b0110 gives gnt=0010 first.
REQ-032 req=0 for 20 cycles, with rel toggling -> gnt stays 0000, gnt_valid=0, timeout=0 throughout.
